pc_control_unit: RTL and testbench

Program counter and multi-cycle control sequencer for the 8-bit accumulator CPU. It drives prog_count into the 16-entry instruction memory and latches the returned 8-bit instruction into an instruction register (IR). It decodes IR[7:4] as the opcode and IR[3:0] as the operand, then issues one-cycle write strobes to the accumulator, register file and ALU. It resolves conditional jumps and stops the machine on HALT.

---
 rtl/pc_control_unit.sv | 153 +++++++++++++++
 tb/tb_pc_control_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_control_unit.sv
// rtl/pc_control_unit.sv - program counter and FETCH/DECODE/EXECUTE sequencer for the 8-bit accumulator CPU
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               lets the sequencer leave IDLE
//   ins_val           instruction word read from instruction memory at prog_count
//   acc_zero          accumulator-is-zero flag, used by conditional jumps in EXECUTE
//   reg_rdata         register-file read data; low bits are the register jump target
//   prog_count        instruction memory address
//   reg_addr, imm     operand field of the instruction register
//   alu_op, acc_src   datapath selects, meaningful while acc_we is high
//   acc_we, reg_we    one-cycle write strobes issued in EXECUTE
//   halted            machine stopped on HALT
//   state             00 IDLE, 01 FETCH, 10 DECODE, 11 EXECUTE or HALT
module pc_control_unit #(
    parameter int word_size  = 8,
    parameter int index_size = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [word_size-1:0]  ins_val,
    input  logic                  acc_zero,
    input  logic [word_size-1:0]  reg_rdata,
    output logic [index_size-1:0] prog_count,
    output logic [index_size-1:0] reg_addr,
    output logic [index_size-1:0] imm,
    output logic [1:0]            alu_op,
    output logic                  acc_we,
    output logic [1:0]            acc_src,
    output logic                  reg_we,
    output logic                  halted,
    output logic [1:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [index_size-1:0] PC_ONE = index_size'(1);

    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_NOR    = 4'b0011;
    localparam logic [3:0] OP_LDREG  = 4'b0100;
    localparam logic [3:0] OP_STREG  = 4'b0101;
    localparam logic [3:0] OP_JZREG  = 4'b0110;
    localparam logic [3:0] OP_JZIMM  = 4'b0111;
    localparam logic [3:0] OP_SHL    = 4'b1011;
    localparam logic [3:0] OP_SHR    = 4'b1100;
    localparam logic [3:0] OP_LDIMM  = 4'b1101;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    state_t                  state_q, state_d;
    logic [index_size-1:0]   pc_q, pc_d;
    logic [word_size-1:0]    ir_q, ir_d;

    logic [3:0]              opcode;
    logic [index_size-1:0]   operand;

    // Only the low bits of reg_rdata form a jump target.
    logic                    unused_rdata_hi;
    assign unused_rdata_hi = ^reg_rdata[word_size-1:index_size];

    assign opcode  = ir_q[word_size-1 -: 4];
    assign operand = ir_q[index_size-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next state and PC; reads inputs only to form registered values.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = ins_val;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_ONE;
                unique case (opcode)
                    OP_JZREG: if (acc_zero) pc_d = reg_rdata[index_size-1:0];
                    OP_JZIMM: if (acc_zero) pc_d = operand;
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are a function of state and IR only, so no input reaches an output.
    always_comb begin
        acc_we  = 1'b0;
        reg_we  = 1'b0;
        alu_op  = 2'b00;
        acc_src = 2'b00;
        if (state_q == S_EXECUTE) begin
            unique case (opcode)
                OP_ADD:   begin alu_op = 2'b00; acc_we = 1'b1; end
                OP_SUB:   begin alu_op = 2'b01; acc_we = 1'b1; end
                OP_NOR:   begin alu_op = 2'b10; acc_we = 1'b1; end
                OP_LDREG: begin alu_op = 2'b11; acc_we = 1'b1; end
                OP_STREG: reg_we = 1'b1;
                OP_SHL:   begin acc_src = 2'b10; acc_we = 1'b1; end
                OP_SHR:   begin acc_src = 2'b11; acc_we = 1'b1; end
                OP_LDIMM: begin acc_src = 2'b01; acc_we = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            S_IDLE:   state = 2'b00;
            S_FETCH:  state = 2'b01;
            S_DECODE: state = 2'b10;
            default:  state = 2'b11;
        endcase
    end

    assign halted     = (state_q == S_HALT);
    assign prog_count = pc_q;
    assign reg_addr   = operand;
    assign imm        = operand;

endmodule

// File: tb/tb_pc_control_unit.sv
// tb/tb_pc_control_unit.sv - randomized self-checking bench for pc_control_unit
module tb_pc_control_unit;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] ins_val;
    logic       acc_zero;
    logic [7:0] reg_rdata;
    logic [3:0] prog_count;
    logic [3:0] reg_addr;
    logic [3:0] imm;
    logic [1:0] alu_op;
    logic       acc_we;
    logic [1:0] acc_src;
    logic       reg_we;
    logic       halted;
    logic [1:0] state;

    pc_control_unit #(.word_size(8), .index_size(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ins_val    (ins_val),
        .acc_zero   (acc_zero),
        .reg_rdata  (reg_rdata),
        .prog_count (prog_count),
        .reg_addr   (reg_addr),
        .imm        (imm),
        .alu_op     (alu_op),
        .acc_we     (acc_we),
        .acc_src    (acc_src),
        .reg_we     (reg_we),
        .halted     (halted),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] imem [16];
    assign ins_val = imem[prog_count];

    int tests_run = 0;
    int tests_failed = 0;

    int force_az = -1;
    int force_rd = -1;

    int exp_pc;
    logic [7:0] exp_ir;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        acc_zero  = (force_az >= 0) ? force_az[0] : 1'($urandom_range(0, 1));
        reg_rdata = (force_rd >= 0) ? force_rd[7:0] : 8'($urandom);
    endtask

    // Spec table: {acc_we, reg_we, acc_src, alu_op} in EXECUTE for each opcode.
    function automatic logic [5:0] exp_ctrl(input logic [3:0] op);
        case (op)
            4'h1:    return {1'b1, 1'b0, 2'b00, 2'b00};
            4'h2:    return {1'b1, 1'b0, 2'b00, 2'b01};
            4'h3:    return {1'b1, 1'b0, 2'b00, 2'b10};
            4'h4:    return {1'b1, 1'b0, 2'b00, 2'b11};
            4'h5:    return {1'b0, 1'b1, 2'b00, 2'b00};
            4'hB:    return {1'b1, 1'b0, 2'b10, 2'b00};
            4'hC:    return {1'b1, 1'b0, 2'b11, 2'b00};
            4'hD:    return {1'b1, 1'b0, 2'b01, 2'b00};
            default: return 6'b0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        drive_rand();
        tick();
        rst_n  = 1'b1;
        exp_pc = 0;
        exp_ir = 8'h00;
    endtask

    task automatic start_run();
        check_eq("idle_state", state, 0);
        check_eq("idle_pc", prog_count, 0);
        run = 1'b1;
        tick();
    endtask

    // Runs one instruction from FETCH through the edge ending EXECUTE.
    task automatic exec_one(output bit did_halt);
        logic [7:0] instr;
        logic [5:0] ctl;
        logic       az;
        logic [7:0] rd;
        int         nxt;
        instr    = imem[exp_pc];
        did_halt = 1'b0;
        check_eq("fetch_state", state, 1);
        check_eq("fetch_pc", prog_count, exp_pc);
        check_eq("fetch_strobes", {acc_we, reg_we}, 0);
        check_eq("fetch_regaddr", reg_addr, exp_ir[3:0]);
        drive_rand();
        tick();
        exp_ir = instr;
        check_eq("decode_state", state, 2);
        check_eq("decode_strobes", {acc_we, reg_we}, 0);
        check_eq("decode_regaddr", reg_addr, instr[3:0]);
        check_eq("decode_imm", imm, instr[3:0]);
        drive_rand();
        tick();
        ctl = exp_ctrl(instr[7:4]);
        check_eq("exec_state", state, 3);
        check_eq("exec_halted", halted, 0);
        check_eq("exec_acc_we", acc_we, ctl[5]);
        check_eq("exec_reg_we", reg_we, ctl[4]);
        check_eq("exec_regaddr", reg_addr, instr[3:0]);
        if (ctl[5]) begin
            check_eq("exec_acc_src", acc_src, ctl[3:2]);
            check_eq("exec_alu_op", alu_op, ctl[1:0]);
        end
        drive_rand();
        az = acc_zero;
        rd = reg_rdata;
        if (instr[7:4] == 4'hF)                nxt = exp_pc;
        else if (instr[7:4] == 4'h6 && az)     nxt = rd % 16;
        else if (instr[7:4] == 4'h7 && az)     nxt = instr % 16;
        else                                    nxt = (exp_pc + 1) % 16;
        tick();
        exp_pc = nxt;
        if (instr[7:4] == 4'hF) begin
            did_halt = 1'b1;
            check_eq("halt_flag", halted, 1);
            check_eq("halt_state", state, 3);
            check_eq("halt_pc", prog_count, exp_pc);
        end else begin
            check_eq("post_exec_pc", prog_count, exp_pc);
        end
    endtask

    task automatic check_frozen(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            run = 1'($urandom_range(0, 1));
            drive_rand();
            tick();
            check_eq("frozen_halted", halted, 1);
            check_eq("frozen_pc", prog_count, exp_pc);
            check_eq("frozen_strobes", {acc_we, reg_we}, 0);
        end
    endtask

    bit h;
    logic [7:0] b;
    logic [7:0] prog6 [6];

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        acc_zero = 1'b0;
        reg_rdata = 8'h00;
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;

        // Reset and idle with run low.
        do_reset();
        check_eq("rst_halted", halted, 0);
        check_eq("rst_strobes", {acc_we, reg_we, acc_src, alu_op}, 0);
        for (int i = 0; i < 10; i++) begin
            drive_rand();
            tick();
            check_eq("idle_hold_state", state, 0);
            check_eq("idle_hold_pc", prog_count, 0);
            check_eq("idle_hold_strobes", {acc_we, reg_we}, 0);
        end

        // Reset asserted mid-EXECUTE kills the strobe immediately.
        imem[0] = 8'hD8;
        start_run();
        tick();
        tick();
        check_eq("midexec_acc_we_before", acc_we, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midexec_acc_we_after", acc_we, 0);
        check_eq("midexec_state_after", state, 0);
        check_eq("midexec_pc_after", prog_count, 0);
        do_reset();

        // Load/store/ALU program.
        prog6 = '{8'hD8, 8'h51, 8'hD5, 8'h52, 8'h41, 8'h12};
        for (int i = 0; i < 16; i++) imem[i] = (i < 6) ? prog6[i] : 8'h00;
        start_run();
        for (int i = 0; i < 6; i++) exec_one(h);
        check_eq("prog6_pc", prog_count, 6);
        do_reset();

        // JZ imm taken and not taken.
        imem[0] = 8'h7A;
        force_az = 1;
        start_run();
        exec_one(h);
        check_eq("jz_imm_taken", prog_count, 10);
        do_reset();
        force_az = 0;
        start_run();
        exec_one(h);
        check_eq("jz_imm_not_taken", prog_count, 1);
        do_reset();

        // JZ reg, upper target bits ignored.
        imem[0] = 8'h67;
        force_az = 1;
        force_rd = 8'h05;
        start_run();
        exec_one(h);
        check_eq("jz_reg_05", prog_count, 5);
        do_reset();
        force_rd = 8'hF5;
        start_run();
        exec_one(h);
        check_eq("jz_reg_f5", prog_count, 5);
        force_az = -1;
        force_rd = -1;
        do_reset();

        // HALT at address 12, then reset clears it.
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
        imem[12] = 8'hF0;
        start_run();
        for (int i = 0; i < 13; i++) exec_one(h);
        check_eq("halt_seen", h, 1);
        check_eq("halt_at_12", prog_count, 12);
        check_frozen(22);
        rst_n = 1'b0;
        #1;
        check_eq("halt_rst_halted", halted, 0);
        check_eq("halt_rst_pc", prog_count, 0);
        do_reset();

        // Wrap past 15 with an illegal opcode there.
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
        imem[15] = 8'hE3;
        start_run();
        for (int i = 0; i < 17; i++) exec_one(h);
        check_eq("wrap_pc", prog_count, 1);
        do_reset();

        // Random programs against the instruction-level model.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) begin
                b = 8'($urandom);
                if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'h0;
                imem[i] = b;
            end
            start_run();
            h = 1'b0;
            for (int n = 0; n < 40 && !h; n++) exec_one(h);
            if (h) check_frozen(5);
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
